// File: rtl/mdu_pkg.sv
// Shared encodings and small decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // Operand A is signed for MUL, MULH, MULHSU, DIV and REM.
   function automatic logic a_signed(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // Operand B is signed for MUL, MULH, DIV and REM (MULHSU treats B as unsigned).
   function automatic logic b_signed(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add for multiply, restoring trial subtract for divide.
module mdu_iter_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               div_mode,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opb_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      // Multiply: acc = {hi, lo}, lo holds the remaining multiplier bits.
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : (WIDTH+1)'(0));
      // Divide: acc = {rem, quot}, shift left one and try subtracting the divisor.
      rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
      ge     = rem_sh >= {1'b0, opb_i};
      diff   = WIDTH'(rem_sh - {1'b0, opb_i});
      if (div_mode) begin
         acc_o = {(ge ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
      end else begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake; one iteration per cycle
// on magnitudes, sign fix-up applied once in DONE.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       MDop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Busy
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;

   logic [W2-1:0]    acc_step;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quot, rem, fix;

   mdu_iter_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (is_div(op_q)),
      .acc_i    (acc_q),
      .opb_i    (opb_q),
      .acc_o    (acc_step)
   );

   // Operand magnitudes for the request currently on the inputs.
   always_comb begin
      a_neg = a_signed(MDop) & A[WIDTH-1];
      b_neg = b_signed(MDop) & B[WIDTH-1];
      a_abs = a_neg ? (~A + WIDTH'(1)) : A;
      b_abs = b_neg ? (~B + WIDTH'(1)) : B;
   end

   // Sign fix-up of the unsigned core result.
   always_comb begin
      prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
      quot     = acc_q[WIDTH-1:0];
      rem      = acc_q[W2-1:WIDTH];
      if (is_div(op_q)) begin
         if (op_q[1]) fix = neg_rem_q ? (~rem + WIDTH'(1)) : rem;
         else         fix = neg_res_q ? (~quot + WIDTH'(1)) : quot;
      end else if (op_q == MD_MUL) begin
         fix = prod_fix[WIDTH-1:0];
      end else begin
         fix = prod_fix[W2-1:WIDTH];
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      neg_res_d   = neg_res_q;
      neg_rem_d   = neg_rem_q;
      acc_d       = acc_q;
      opb_d       = opb_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;

      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  op_d      = MDop;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  opb_d     = is_div(MDop) ? b_abs : a_abs;
                  if (is_div(MDop) && (B == '0)) begin
                     // Divide-by-zero: quotient all-ones, remainder is the dividend.
                     acc_d     = {a_abs, {WIDTH{1'b1}}};
                     neg_res_d = 1'b0;
                     state_d   = S_DONE;
                  end else begin
                     acc_d   = is_div(MDop) ? {WIDTH'(0), a_abs} : {WIDTH'(0), b_abs};
                     cnt_d   = CW'(WIDTH);
                     state_d = S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_d = acc_step;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
               if (!out_valid_q) begin
                  result_d    = fix;
                  out_valid_d = 1'b1;
               end else if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      in_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= 3'b000;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         acc_q       <= '0;
         opb_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         neg_res_q   <= neg_res_d;
         neg_rem_q   <= neg_rem_d;
         acc_q       <= acc_d;
         opb_q       <= opb_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign Busy      = busy_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a 64-bit arithmetic reference model.
module tb_mul_div_unit;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0] a, b, result;
   logic [2:0]   mdop;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .B         (b),
      .MDop      (mdop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (result),
      .Busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // RV32M semantics computed with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
      longint      sx, sy, ux, uy;
      logic [63:0] p;
      logic [31:0] r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      p  = '0;
      case (op)
         3'd0:    begin p = 64'(sx * sy); r = p[31:0];  end
         3'd1:    begin p = 64'(sx * sy); r = p[63:32]; end
         3'd2:    begin p = 64'(sx * uy); r = p[63:32]; end
         3'd3:    begin p = 64'(ux * uy); r = p[63:32]; end
         3'd4:    r = (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
         3'd5:    r = (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
         3'd6:    r = (y == 0) ? x : 32'(sx % sy);
         default: r = (y == 0) ? x : 32'(ux % uy);
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one request, wait for the result, check latency/value/handshake, then hand it off.
   task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int hold, input string tag);
      int   cyc;
      logic bad_rdy, bad_hold;
      logic [31:0] exp_lat;
      @(negedge clk);
      chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; mdop = op; a = x; b = y;
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; mdop = 3'($urandom);
      cyc = 0; bad_rdy = 1'b0;
      while (!out_valid && cyc < 100) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) bad_rdy = 1'b1;
         @(negedge clk);
         cyc++;
      end
      exp_lat = (op[2] && y == 32'd0) ? 32'd1 : 32'(W + 1);
      chk({tag, "_busy"},    32'(bad_rdy), 32'd0);
      chk({tag, "_latency"}, 32'(cyc), exp_lat);
      chk({tag, "_valid"},   32'(out_valid), 32'd1);
      chk({tag, "_result"},  result, exp);
      bad_hold = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (result !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad_hold = 1'b1;
      end
      chk({tag, "_hold"}, 32'(bad_hold), 32'd0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, "_handoff"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
      chk({tag, "_keep"}, result, exp);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
      int          hold;
   } dir_t;

   dir_t dirs[$];

   initial begin
      logic saw;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; mdop = '0;
      #12;
      chk("reset", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
      chk("reset_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      dirs.push_back('{3'd0, 32'd7,          32'd6,          32'h0000_002A, 0});
      dirs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1});
      dirs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 0});
      dirs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 2});
      dirs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 0});
      dirs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 0});
      dirs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,        0});
      dirs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,         10});
      dirs.push_back('{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 0});
      dirs.push_back('{3'd7, 32'd5,          32'd0,          32'd5,         0});
      dirs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 0});
      dirs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 0});
      dirs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 0});
      foreach (dirs[i])
         run_op(dirs[i].op, dirs[i].x, dirs[i].y, dirs[i].exp, dirs[i].hold,
                $sformatf("dir%0d", i));

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic [31:0] x, y;
         op = 3'($urandom_range(0, 7));
         x  = pick();
         y  = pick();
         run_op(op, x, y, ref_md(op, x, y), $urandom_range(0, 3), $sformatf("rnd%0d", i));
      end

      // Flush mid-CALC: back to IDLE, no result ever appears.
      @(negedge clk);
      in_valid = 1'b1; mdop = 3'd0; a = 32'd123; b = 32'd456;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_calc", {29'd0, out_valid, in_ready, busy}, 32'b010);
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      chk("flush_no_result", 32'(saw), 32'd0);

      // Flush wins over a request presented in the same cycle.
      flush = 1'b1; in_valid = 1'b1; mdop = 3'd5; a = 32'd9; b = 32'd3;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_vs_accept", {29'd0, out_valid, in_ready, busy}, 32'b010);

      // Flush while a result is waiting drops it.
      in_valid = 1'b1; mdop = 3'd4; a = 32'd5; b = 32'd0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_done_pre", 32'(out_valid), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_done", {29'd0, out_valid, in_ready, busy}, 32'b010);

      // Async reset mid-CALC takes effect without a clock edge.
      in_valid = 1'b1; mdop = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_reset", {29'd0, out_valid, in_ready, busy}, 32'b010);
      chk("async_reset_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 0, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
